ma_stage: RTL

Memory-access stage of the SimpleRisc pipeline, sitting directly downstream of the EX/MA pipeline register and upstream of the MA/RW register. Accepts one instruction at a time from EX/MA, performs `ld`/`st` through a req/ack data-memory port, and presents a registered result bundle to the MA/RW stage. Back-pressures EX/MA with a ready signal while a memory access or an unconsumed result is outstanding.

---
 rtl/ma_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ma_stage.sv
// ma_stage: memory-access stage of the SimpleRisc pipeline.
// Takes one instruction from EX/MA and performs ld/st over a req/ack data
// port. It then holds a registered result bundle for MA/RW.
// Optional feature: define MA_TIMEOUT_EN to bound the memory wait at
// TIMEOUT_CYCLES cycles. A timed-out access completes with Mem_Err = 1.
module ma_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] Alu_Result,
  input  logic [31:0] Op2,
  input  logic [31:0] PC_Current,
  input  logic [3:0]  Rd,
  input  logic        IsLd,
  input  logic        IsSt,
  input  logic        IsWb,
  input  logic        IsCall,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Wdata,
  input  logic [31:0] Mem_Rdata,
  input  logic        Mem_Ack,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Alu_Result,
  output logic [31:0] Out_Ld_Result,
  output logic [31:0] Out_PC_Current,
  output logic [3:0]  Out_Rd,
  output logic        Out_IsLd,
  output logic        Out_IsCall,
  output logic        Out_IsWb,
  output logic        Mem_Err
);

  typedef enum logic {IDLE, MEM} state_t;

  state_t state;
  logic   accept;
  logic   is_mem;

  // A zero wait limit would make the timeout meaningless.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("ma_stage: TIMEOUT_CYCLES must be nonzero");
  end

  // Accept only when idle and the output slot is free or draining now.
  assign In_Ready = (state == IDLE) && (!Out_Valid || Out_Ready);
  assign accept   = In_Valid && In_Ready;
  assign is_mem   = IsLd || IsSt;

`ifdef MA_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // This edge would be the TIMEOUT_CYCLES-th MEM cycle without an ack.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign Mem_Err = 1'b0;
`endif

  // Stage FSM: accepts instructions, runs memory handshakes, loads the bundle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      Mem_Req        <= 1'b0;
      Mem_We         <= 1'b0;
      Mem_Addr       <= '0;
      Mem_Wdata      <= '0;
      Out_Valid      <= 1'b0;
      Out_Alu_Result <= '0;
      Out_Ld_Result  <= '0;
      Out_PC_Current <= '0;
      Out_Rd         <= '0;
      Out_IsLd       <= 1'b0;
      Out_IsCall     <= 1'b0;
      Out_IsWb       <= 1'b0;
`ifdef MA_TIMEOUT_EN
      wait_cnt       <= '0;
      Mem_Err        <= 1'b0;
`endif
    end else begin
      // Consumption by MA/RW; a bundle loaded below on this edge overrides it.
      if (Out_Valid && Out_Ready) Out_Valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            Out_Alu_Result <= Alu_Result;
            Out_PC_Current <= PC_Current;
            Out_Rd         <= Rd;
            Out_IsLd       <= IsLd;
            Out_IsCall     <= IsCall;
            Out_IsWb       <= IsWb;
`ifdef MA_TIMEOUT_EN
            Mem_Err        <= 1'b0;
`endif
            if (is_mem) begin
              // Load takes priority when both IsLd and IsSt are set.
              Mem_Req   <= 1'b1;
              Mem_We    <= IsSt && !IsLd;
              Mem_Addr  <= {Alu_Result[31:2], 2'b00};
              Mem_Wdata <= Op2;
              state     <= MEM;
`ifdef MA_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end else begin
              Out_Ld_Result <= '0;
              Out_Valid     <= 1'b1;
            end
          end
        end

        MEM: begin
          if (Mem_Ack) begin
            Mem_Req       <= 1'b0;
            Out_Ld_Result <= Mem_We ? 32'h0 : Mem_Rdata;
            Out_Valid     <= 1'b1;
            state         <= IDLE;
          end
`ifdef MA_TIMEOUT_EN
          else if (timeout_hit) begin
            Mem_Req       <= 1'b0;
            Out_Ld_Result <= 32'hDEAD_BEEF;
            Out_IsWb      <= 1'b0;
            Out_Valid     <= 1'b1;
            Mem_Err       <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
